div_seq_param: RTL and testbench
================================

# div_seq_param

Parametrised multi-cycle integer divider producing quotient and remainder for W-bit operands, retiring K restoring-division steps per clock. It is the sequential successor to the fixed 32-bit combinational/two-stage divider chain. It adds signed mode, divide-by-zero reporting and valid/ready handshakes on both sides. It sits between an operand-issuing datapath and a result consumer that may apply backpressure.

## Interface
- W, 32, operand/result width; even, ≥ 4
- K, 1, quotient bits retired per clock; legal 1, 2, 4, 8; must divide W
- clk  in  1  clock, all state updates on posedge
- rstn  in  1  reset, synchronous, active-low
- in_valid  in  1  operands presented
- in_ready  out  1  block can accept; combinational, high iff state IDLE
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled at accept
- dividend  in  W  numerator; sampled at accept
- divisor  in  W  denominator; sampled at accept
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  consumer takes result
- quotient  out  W  registered quotient
- remainder  out  W  registered remainder
- div_by_zero  out  1  registered; set with result when divisor was 0

## Operation
- States: IDLE, CALC, DONE. Step counter counts 0 … W/K−1.
- Accept: on a posedge with in_valid && in_ready.
  - Capture |dividend| and |divisor| (magnitudes when in_signed, raw otherwise).
  - Capture the sign flags: neg_q = in_signed & (sign(dividend) ^ sign(divisor)); neg_r = in_signed & sign(dividend).
  - Divisor ≠ 0: IDLE→CALC, clear the counter.
  - Divisor = 0: IDLE→DONE directly. quotient = all ones, remainder = raw dividend, div_by_zero = 1.
- CALC: each clock performs K chained restoring steps on a 2W-bit partial remainder register.
  - Per step: trial = {part[2W−2:0],1'b0} − {divisor, W'b0}, computed W+1 bits wide at the top.
  - On borrow: keep the shifted value, quotient bit 0. Otherwise: take the trial, quotient bit 1.
  - Quotient bits shift into the low end of the dividend half, MSB first.
- Last CALC cycle (counter = W/K−1): CALC→DONE.
  - quotient ← neg_q ? −q : q.
  - remainder ← neg_r ? −r : r, where r is the top W bits of the partial remainder.
  - div_by_zero ← 0.
- Signed results truncate toward zero. The remainder takes the dividend's sign; |remainder| < |divisor|.
- Signed overflow, MIN / −1: quotient = MIN, remainder = 0, no flag. This falls out of the magnitude path with W-bit wrap.
- DONE: out_valid = 1. On out_valid && out_ready, DONE→IDLE.
- While out_valid && !out_ready, quotient, remainder and div_by_zero are held bit-stable.
- All arithmetic is mod 2^W on the result ports. Internal magnitudes are W bits unsigned (|MIN| = 2^(W−1) fits).

## Timing
- Reset values: out_valid 0, quotient 0, remainder 0, div_by_zero 0, state IDLE, so in_ready = 1 one cycle after rstn is sampled low.
- Normal latency: accept at edge E; out_valid is high after edge E + W/K (W=32,K=1: 32 cycles; K=4: 8 cycles).
- Divide-by-zero latency: out_valid is high after edge E (next cycle).
- Throughput: in_ready is low in CALC and DONE; there is no overlap. With out_ready held high, the earliest next accept is edge E + W/K + 2.
- The out handshake completes on the posedge where out_valid && out_ready. out_valid drops after that edge.
- in_valid with in_ready low is ignored; operands need not be held.
- Reset mid-CALC or mid-DONE aborts the operation. After that edge the state is IDLE and all outputs are at reset values; the pending result is lost, not emitted.
- Operand changes during CALC/DONE have no effect.

## Test plan
- W=32, K=1, unsigned 100 / 7 -> quotient 14, remainder 2, div_by_zero 0; out_valid rises exactly 32 cycles after accept.
- Signed −7 / 2 (0xFFFFFFF9 / 0x2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / −2 -> quotient 0xFFFFFFFD, remainder 1.
- 5 / 0, in_signed both values -> quotient 0xFFFFFFFF, remainder 5, div_by_zero 1, out_valid one cycle after accept. Then 6 / 3 -> div_by_zero 0.
- 0x80000000 / 0xFFFFFFFF: signed -> quotient 0x80000000, remainder 0. Unsigned -> quotient 0, remainder 0x80000000.
- Backpressure, K=4: 0xFFFFFFFF / 0x10 with out_ready low for 10 cycles -> result 0x0FFFFFFF rem 0xF on cycle 8. Outputs and in_ready=0 stable throughout, in_valid pulses ignored; retires on the first out_ready edge; in_ready high the next cycle.
- rstn low at CALC step 10 -> next cycle out_valid 0, in_ready 1, outputs 0. A fresh 9 / 3 then returns quotient 3, remainder 0 with full latency.

Source files
------------

// File: rtl/div_seq_param.sv
// Multi-cycle restoring divider: W-bit quotient/remainder, K quotient bits per clock,
// optional two's-complement operands, divide-by-zero flag, valid/ready on both sides.
module div_seq_param #(
    parameter int W = 32,
    parameter int K = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_signed,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(W / K) + 1;
    localparam logic [CW-1:0] C_LAST = CW'(W / K - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [2*W-1:0] r_part;
    logic [W-1:0]   r_dvsr;
    logic [CW-1:0]  r_cnt;
    logic           r_neg_q;
    logic           r_neg_r;
    logic           r_out_valid;
    logic [W-1:0]   r_quot;
    logic [W-1:0]   r_rem;
    logic           r_dbz;

    logic           w_dvd_neg;
    logic           w_dvs_neg;
    logic [W-1:0]   w_dvd_mag;
    logic [W-1:0]   w_dvs_mag;
    logic           w_dvs_zero;
    logic           w_accept;
    logic [2*W-1:0] w_chain;
    logic [W:0]     w_diff;
    logic [W-1:0]   w_q_mag;
    logic [W-1:0]   w_r_mag;

    // Magnitudes are W-bit unsigned; |MIN| = 2^(W-1) still fits.
    assign w_dvd_neg  = in_signed & dividend[W-1];
    assign w_dvs_neg  = in_signed & divisor[W-1];
    assign w_dvd_mag  = w_dvd_neg ? (~dividend + {{(W-1){1'b0}}, 1'b1}) : dividend;
    assign w_dvs_mag  = w_dvs_neg ? (~divisor + {{(W-1){1'b0}}, 1'b1}) : divisor;
    assign w_dvs_zero = (divisor == {W{1'b0}});
    assign w_accept   = in_valid && (r_state == IDLE);

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = r_out_valid;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

    // K chained restoring steps; the shifted remainder needs W+1 bits at the top.
    always_comb begin
        w_chain = r_part;
        w_diff  = {(W+1){1'b0}};
        for (int s = 0; s < K; s++) begin
            w_diff = w_chain[2*W-1:W-1] - {1'b0, r_dvsr};
            if (w_diff[W]) begin
                w_chain = {w_chain[2*W-2:0], 1'b0};
            end else begin
                w_chain = {w_diff[W-1:0], w_chain[W-2:0], 1'b1};
            end
        end
    end

    assign w_q_mag = w_chain[W-1:0];
    assign w_r_mag = w_chain[2*W-1:W];

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_nxt = w_dvs_zero ? DONE : CALC;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CALC: begin
                if (r_cnt == C_LAST) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_part      <= {(2*W){1'b0}};
            r_dvsr      <= {W{1'b0}};
            r_cnt       <= {CW{1'b0}};
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_out_valid <= 1'b0;
            r_quot      <= {W{1'b0}};
            r_rem       <= {W{1'b0}};
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_part  <= {{W{1'b0}}, w_dvd_mag};
                        r_dvsr  <= w_dvs_mag;
                        r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_r <= w_dvd_neg;
                        r_cnt   <= {CW{1'b0}};
                        if (w_dvs_zero) begin
                            r_quot      <= {W{1'b1}};
                            r_rem       <= dividend;
                            r_dbz       <= 1'b1;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r_part <= w_chain;
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == C_LAST) begin
                        r_quot      <= r_neg_q ? (~w_q_mag + {{(W-1){1'b0}}, 1'b1}) : w_q_mag;
                        r_rem       <= r_neg_r ? (~w_r_mag + {{(W-1){1'b0}}, 1'b1}) : w_r_mag;
                        r_dbz       <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_param.sv
// Scoreboard bench for div_seq_param: a K=1 instance for function/latency/reset and a
// K=4 instance for backpressure. Expected results are pushed at accept, popped at out_valid.
module tb_div_seq_param;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int tests_run = 0;
    int tests_failed = 0;

    logic clk = 1'b0;
    logic rstn = 1'b0;

    logic        in_valid = 1'b0, in_signed = 1'b0, out_ready = 1'b1;
    logic [31:0] dividend = 32'd0, divisor = 32'd0;
    logic        in_ready, out_valid, div_by_zero;
    logic [31:0] quotient, remainder;

    logic        b_in_valid = 1'b0, b_in_signed = 1'b0, b_out_ready = 1'b1;
    logic [31:0] b_dividend = 32'd0, b_divisor = 32'd0;
    logic        b_in_ready, b_out_valid, b_div_by_zero;
    logic [31:0] b_quotient, b_remainder;

    always #5 clk = ~clk;

    div_seq_param #(.W(32), .K(1)) dut1 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_signed(in_signed), .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero)
    );

    div_seq_param #(.W(32), .K(4)) dut4 (
        .clk(clk), .rstn(rstn), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_signed(b_in_signed), .dividend(b_dividend), .divisor(b_divisor),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .quotient(b_quotient),
        .remainder(b_remainder), .div_by_zero(b_div_by_zero)
    );

    // Reference behaviour from native operators; MIN / -1 wraps to MIN rem 0.
    function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic signed [31:0] sx, sy;
        sx = a;
        sy = b;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF; e.r = a; e.dbz = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000; e.r = 32'd0; e.dbz = 1'b0;
        end else if (s) begin
            e.q = sx / sy; e.r = sx % sy; e.dbz = 1'b0;
        end else begin
            e.q = a / b; e.r = a % b; e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Starts and ends on a negedge; back-to-back calls accept at the earliest legal edge.
    task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz,
                         input int elat, input string name);
        exp_t e;
        int n;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s in_ready_before: got %b want 1", name, in_ready);
        end
        in_signed = s; dividend = a; divisor = b; in_valid = 1'b1;
        e.q = eq; e.r = er; e.dbz = edz;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0; dividend = $urandom; divisor = $urandom; in_signed = ~s;
        n = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n !== elat) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d want %0d", name, n, elat);
        end
        e = sb.pop_front();
        tests_run++;
        if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz) begin
            tests_failed++;
            $display("FAIL %s result: got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                     name, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
        end
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s retire: got out_valid=%b in_ready=%b want 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 32'd0 ||
            remainder !== 32'd0 || div_by_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_k1: got ov=%b ir=%b q=%h r=%h dbz=%b want 0 1 0 0 0",
                     out_valid, in_ready, quotient, remainder, div_by_zero);
        end
        tests_run++;
        if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_quotient !== 32'd0 ||
            b_remainder !== 32'd0 || b_div_by_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_k4: got ov=%b ir=%b q=%h r=%h dbz=%b want 0 1 0 0 0",
                     b_out_valid, b_in_ready, b_quotient, b_remainder, b_div_by_zero);
        end
        rstn = 1'b1;
    endtask

    task automatic test_directed();
        do_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32, "u100_7");
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 32, "s-7_2");
        do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 32, "s7_-2");
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 32, "s_min_-1");
        do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 32, "u_min_max");
    endtask

    task automatic test_div_by_zero();
        do_op(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0, "u5_0");
        do_op(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0, "s5_0");
        do_op(1'b0, 32'd6, 32'd3, 32'd2, 32'd0, 1'b0, 32, "u6_3_after_dbz");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] a, b;
        logic s;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : 32'($urandom);
            if (i == 5) b = 32'd0;
            s = 1'($urandom_range(0, 1));
            e = model(s, a, b);
            do_op(s, a, b, e.q, e.r, e.dbz, (b == 32'd0) ? 0 : 32, "rand");
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int n;
        logic [31:0] hq, hr;
        logic hd;
        b_out_ready = 1'b0; b_in_signed = 1'b0;
        b_dividend = 32'hFFFF_FFFF; b_divisor = 32'h10; b_in_valid = 1'b1;
        e.q = 32'h0FFF_FFFF; e.r = 32'hF; e.dbz = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (b_out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n !== 8) begin
            tests_failed++;
            $display("FAIL bp_latency: got %0d want 8", n);
        end
        e = sb.pop_front();
        tests_run++;
        if (b_quotient !== e.q || b_remainder !== e.r || b_div_by_zero !== e.dbz) begin
            tests_failed++;
            $display("FAIL bp_result: got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                     b_quotient, b_remainder, b_div_by_zero, e.q, e.r, e.dbz);
        end
        hq = e.q; hr = e.r; hd = e.dbz;
        for (int i = 0; i < 10; i++) begin
            b_in_valid = (i % 2 == 0);
            b_dividend = $urandom; b_divisor = $urandom;
            @(negedge clk);
            tests_run++;
            if (b_out_valid !== 1'b1 || b_in_ready !== 1'b0 || b_quotient !== hq ||
                b_remainder !== hr || b_div_by_zero !== hd) begin
                tests_failed++;
                $display("FAIL bp_hold%0d: got ov=%b ir=%b q=%h r=%h dbz=%b want 1 0 %h %h %b",
                         i, b_out_valid, b_in_ready, b_quotient, b_remainder, b_div_by_zero, hq, hr, hd);
            end
        end
        b_in_valid = 1'b0;
        b_out_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_retire: got ov=%b ir=%b want 0 1", b_out_valid, b_in_ready);
        end
    endtask

    task automatic test_reset_mid_calc();
        in_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 32'd0 ||
            remainder !== 32'd0 || div_by_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_calc_reset: got ov=%b ir=%b q=%h r=%h dbz=%b want 0 1 0 0 0",
                     out_valid, in_ready, quotient, remainder, div_by_zero);
        end
        rstn = 1'b1;
        do_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 32, "u9_3_after_reset");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_div_by_zero();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_calc();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
